// File: rtl/padder_result_queue_if.sv
// Result stream leaving the padder result queue.
// Ready/valid handshake carrying {tag, carry, sum}.
interface padder_result_queue_if #(
    parameter int TAG_W = 4
) ();
    logic             valid;
    logic             ready;
    logic [31:0]      sum;
    logic             carry;
    logic [TAG_W-1:0] tag;

    modport master (
        output valid, sum, carry, tag,
        input  ready
    );

    modport slave (
        input  valid, sum, carry, tag,
        output ready
    );
endinterface

// File: rtl/padder_result_queue.sv
// Result capture queue behind the pipelined 32-bit adder.
// Credit-throttled issue; results come back in issue order.
module padder_result_queue #(
    parameter  int LATENCY = 4,
    parameter  int DEPTH   = 8,
    parameter  int TAG_W   = 4,
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int FW      = $clog2(LATENCY + 1),
    localparam int PW      = $clog2(DEPTH)
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 IssueValid,
    input  logic [TAG_W-1:0]     IssueTag,
    output logic                 IssueReady,
    input  logic [31:0]          S,
    input  logic                 CO,
    padder_result_queue_if.master out_if,
    output logic [CW-1:0]        Count,
    output logic [FW-1:0]        InFlight
);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             carry;
        logic [31:0]      sum;
    } entry_t;

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [TAG_W-1:0]   tag_q [LATENCY];
    entry_t             mem_q [DEPTH];
    logic [PW-1:0]      wr_q, rd_q;
    logic [CW-1:0]      cnt_q;
    logic [FW-1:0]      inflight;
    entry_t             head;
    logic               accept, push, pop;

    assign accept = IssueValid && IssueReady;
    assign push   = vld_q[LATENCY-1];
    assign pop    = out_if.valid && out_if.ready;

    always_comb begin
        vld_d    = '0;
        vld_d[0] = accept;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + FW'(vld_q[i]);
        end
    end

    // Credits come from registered state only; a same-cycle pop grants nothing.
    assign IssueReady = (int'(cnt_q) + int'(inflight)) < DEPTH;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
            for (int j = 0; j < DEPTH; j++) begin
                mem_q[j] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            vld_q    <= vld_d;
            tag_q[0] <= IssueTag;
            for (int i = 1; i < LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (push) begin
                mem_q[wr_q] <= '{tag: tag_q[LATENCY-1], carry: CO, sum: S};
                wr_q        <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head         = mem_q[rd_q];
    assign out_if.valid = (cnt_q != '0);
    assign out_if.sum   = head.sum;
    assign out_if.carry = head.carry;
    assign out_if.tag   = head.tag;
    assign Count        = cnt_q;
    assign InFlight     = inflight;

    a_no_overflow: assert property (
        @(posedge Clock) disable iff (!Reset_n)
        !(push && cnt_q == CW'(DEPTH))
    );

endmodule

// File: tb/tb_padder_result_queue.sv
// Bench for padder_result_queue with a behavioural 4-stage adder.
// Scoreboard of expected {tag, carry, sum} in issue order.
module tb_padder_result_queue;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        IssueValid;
    logic [3:0]  IssueTag;
    logic        IssueReady;
    logic [31:0] A, B, S;
    logic        CI, CO;
    logic [3:0]  Count;
    logic [2:0]  InFlight;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pops  = 0;
    int pushes = 0;
    int first_pop = -1;
    int last_pop  = -1;
    logic [36:0] exp_q[$];

    always #5 Clock = ~Clock;

    padder_result_queue_if #(.TAG_W(4)) oif ();

    padder_result_queue #(
        .LATENCY(4), .DEPTH(8), .TAG_W(4)
    ) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .IssueValid (IssueValid),
        .IssueTag   (IssueTag),
        .IssueReady (IssueReady),
        .S          (S),
        .CO         (CO),
        .out_if     (oif),
        .Count      (Count),
        .InFlight   (InFlight)
    );

    // Unreset adder pipeline, as in the real datapath.
    logic [32:0] apipe [4];
    always @(posedge Clock) begin
        apipe[0] <= {1'b0, A} + {1'b0, B} + {32'd0, CI};
        for (int i = 1; i < 4; i++) apipe[i] <= apipe[i-1];
    end
    assign {CO, S} = apipe[3];

    task automatic tick();
        logic [36:0] e;
        logic [32:0] r;
        if (Reset_n) begin
            if (IssueValid && IssueReady) begin
                r = {1'b0, A} + {1'b0, B} + {32'd0, CI};
                exp_q.push_back({IssueTag, r});
                pushes++;
            end
            if (oif.valid && oif.ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_pop: got %h, scoreboard empty",
                             {oif.tag, oif.carry, oif.sum});
                end else begin
                    e = exp_q.pop_front();
                    if ({oif.tag, oif.carry, oif.sum} !== e) begin
                        bad++;
                        $display("FAIL sb_result: got %h want %h",
                                 {oif.tag, oif.carry, oif.sum}, e);
                    end
                end
                pops++;
                last_pop = cyc;
                if (first_pop < 0) first_pop = cyc;
            end
        end
        @(posedge Clock);
        #1;
        cyc++;
    endtask

    task automatic drive_op(input logic [3:0] t);
        IssueValid = 1'b1;
        IssueTag   = t;
        A  = $urandom;
        B  = $urandom;
        CI = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        IssueValid = 1'b0;
        IssueTag = '0;
        A = '0; B = '0; CI = 1'b0;
        oif.ready = 1'b0;
        repeat (3) @(posedge Clock);
        #3 Reset_n = 1'b1;
        @(posedge Clock); #1;
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({oif.valid, Count, InFlight, IssueReady} !== 9'b0_0000_000_1) begin
                bad++;
                $display("FAIL reset_idle: v/cnt/fl/rdy=%b want 000000001",
                         {oif.valid, Count, InFlight, IssueReady});
            end
            tick();
        end
        total++;
        if ({oif.tag, oif.carry, oif.sum} !== 37'd0) begin
            bad++;
            $display("FAIL reset_head: got %h want 0",
                     {oif.tag, oif.carry, oif.sum});
        end
    endtask

    task automatic test_single();
        oif.ready = 1'b0;
        IssueValid = 1'b1;
        IssueTag = 4'd3;
        A = 32'h0000_0001; B = 32'hFFFF_FFFF; CI = 1'b0;
        tick();
        IssueValid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            total++;
            if (oif.valid !== (k == 4)) begin
                bad++;
                $display("FAIL single_latency: edge %0d valid=%b want %b",
                         k, oif.valid, (k == 4));
            end
        end
        total++;
        if ({oif.tag, oif.carry, oif.sum, Count} !== {4'd3, 1'b1, 32'd0, 4'd1}) begin
            bad++;
            $display("FAIL single_head: tag=%0d co=%b s=%h cnt=%0d want 3 1 0 1",
                     oif.tag, oif.carry, oif.sum, Count);
        end
        oif.ready = 1'b1;
        tick();
        tick();
        total++;
        if (oif.valid !== 1'b0 || Count !== 4'd0) begin
            bad++;
            $display("FAIL single_drain: valid=%b cnt=%0d want 0 0",
                     oif.valid, Count);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        int p0;
        logic rdy_ok;
        rdy_ok = 1'b1;
        p0 = pops;
        first_pop = -1;
        oif.ready = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 20; i++) begin
            drive_op(4'(i));
            if (IssueReady !== 1'b1) rdy_ok = 1'b0;
            tick();
        end
        IssueValid = 1'b0;
        repeat (10) tick();
        total++;
        if (!rdy_ok) begin
            bad++;
            $display("FAIL b2b_ready: IssueReady=0 seen, want always 1");
        end
        total++;
        if (pops - p0 != 20) begin
            bad++;
            $display("FAIL b2b_count: got %0d results want 20", pops - p0);
        end
        total++;
        if (first_pop - c0 != 5 || last_pop - first_pop != 19) begin
            bad++;
            $display("FAIL b2b_timing: first=%0d span=%0d want 5 19",
                     first_pop - c0, last_pop - first_pop);
        end
    endtask

    task automatic test_fill();
        int a0;
        int p0;
        a0 = pushes;
        oif.ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive_op(4'(i + 5));
            tick();
        end
        total++;
        if (pushes - a0 != 8 || int'(Count) + int'(InFlight) != 8
            || IssueReady !== 1'b0) begin
            bad++;
            $display("FAIL fill_credit: acc=%0d cnt+fl=%0d rdy=%b want 8 8 0",
                     pushes - a0, int'(Count) + int'(InFlight), IssueReady);
        end
        IssueValid = 1'b0;
        repeat (5) tick();
        total++;
        if (Count !== 4'd8 || InFlight !== 3'd0) begin
            bad++;
            $display("FAIL fill_stored: cnt=%0d fl=%0d want 8 0", Count, InFlight);
        end
        p0 = pops;
        oif.ready = 1'b1;
        tick();
        total++;
        if (Count !== 4'd7 || IssueReady !== 1'b1) begin
            bad++;
            $display("FAIL fill_return: cnt=%0d rdy=%b want 7 1", Count, IssueReady);
        end
        repeat (10) tick();
        total++;
        if (pops - p0 != 8 || Count !== 4'd0) begin
            bad++;
            $display("FAIL fill_drain: pops=%0d cnt=%0d want 8 0", pops - p0, Count);
        end
    endtask

    task automatic test_push_pop();
        int p0;
        p0 = pops;
        oif.ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_op(4'(i + 8));
            tick();
        end
        IssueValid = 1'b0;
        repeat (5) tick();
        total++;
        if (Count !== 4'd4) begin
            bad++;
            $display("FAIL pp_setup: cnt=%0d want 4", Count);
        end
        for (int i = 0; i < 4; i++) begin
            drive_op(4'(i + 12));
            tick();
        end
        IssueValid = 1'b0;
        oif.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (Count !== 4'd4) begin
                bad++;
                $display("FAIL pp_steady: step %0d cnt=%0d want 4", i, Count);
            end
        end
        repeat (6) tick();
        total++;
        if (pops - p0 != 8 || Count !== 4'd0) begin
            bad++;
            $display("FAIL pp_drain: pops=%0d cnt=%0d want 8 0", pops - p0, Count);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        oif.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_op(4'(i));
            tick();
        end
        IssueValid = 1'b0;
        repeat (5) tick();
        for (int i = 0; i < 3; i++) begin
            drive_op(4'(i + 9));
            tick();
        end
        IssueValid = 1'b0;
        total++;
        if (Count !== 4'd5 || InFlight !== 3'd3) begin
            bad++;
            $display("FAIL mid_setup: cnt=%0d fl=%0d want 5 3", Count, InFlight);
        end
        #2 Reset_n = 1'b0;
        #1;
        total++;
        if ({oif.valid, Count, InFlight, IssueReady} !== 9'b0_0000_000_1
            || {oif.tag, oif.carry, oif.sum} !== 37'd0) begin
            bad++;
            $display("FAIL mid_async: v/cnt/fl/rdy=%b head=%h want 000000001 0",
                     {oif.valid, Count, InFlight, IssueReady},
                     {oif.tag, oif.carry, oif.sum});
        end
        exp_q.delete();
        repeat (2) @(posedge Clock);
        #3 Reset_n = 1'b1;
        @(posedge Clock); #1;
        oif.ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (oif.valid !== 1'b0 || Count !== 4'd0) seen = 1'b1;
            tick();
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL mid_stale: stale result after reset, want none");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_push_pop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
